// File: rtl/complex_array_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : complex_array_seq_ctrl
// Brief    : Sequencer that streams operand reads into the complex add/sub
//            core and writes its results back, with a drain watchdog.
// Revision : 1.0
// ============================================================================
module complex_array_seq_ctrl #(
    parameter int N_ELEM   = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16,
    parameter int MEM_LAT  = 1,
    parameter int CORE_LAT = 2,
    parameter int TO_CYC   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                operation,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                a_valid,
    output logic                b_valid,
    output logic                core_op,
    input  logic                core_valid,
    input  logic [DATA_W-1:0]   core_re,
    input  logic [DATA_W-1:0]   core_im,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [2*DATA_W-1:0] wr_data
);

    localparam int WD_W = $clog2(TO_CYC + 1);

    // Counters carry one extra bit so N_ELEM = 2^ADDR_W terminates cleanly.
    localparam logic [ADDR_W:0] c_N_ELEM  = (ADDR_W + 1)'(N_ELEM);
    localparam logic [ADDR_W:0] c_CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [WD_W-1:0] c_WD_LAST = WD_W'(TO_CYC - 1);
    localparam logic [WD_W-1:0] c_WD_ONE  = WD_W'(1);

    generate
        if (N_ELEM < 2 || MEM_LAT < 1 || CORE_LAT < 1 || TO_CYC < 1 ||
            (1 << ADDR_W) < N_ELEM) begin : g_param_check
            $error("complex_array_seq_ctrl: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W:0]     r_rd_cnt;
    logic [ADDR_W:0]     r_wr_cnt;
    logic [WD_W-1:0]     r_wd;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_core_op;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [2*DATA_W-1:0] r_wr_data;
    logic [MEM_LAT-1:0]  r_vpipe;
    logic                w_capture;

    // Results are only taken while an operation is in flight and not yet full.
    assign w_capture = core_valid &&
                       (r_state == S_ISSUE || r_state == S_DRAIN) &&
                       (r_wr_cnt < c_N_ELEM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_wd      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_core_op <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_capture;
            if (w_capture) begin
                r_wr_addr <= r_wr_cnt[ADDR_W-1:0];
                r_wr_data <= {core_re, core_im};
                r_wr_cnt  <= r_wr_cnt + c_CNT_ONE;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_ISSUE;
                        r_core_op <= operation;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                        r_rd_cnt  <= c_CNT_ONE;
                        r_wr_cnt  <= '0;
                        r_wd      <= '0;
                    end
                end
                S_ISSUE: begin
                    if (r_rd_cnt == c_N_ELEM) begin
                        r_rd_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_cnt[ADDR_W-1:0];
                        r_rd_cnt  <= r_rd_cnt + c_CNT_ONE;
                    end
                end
                S_DRAIN: begin
                    if (core_valid) begin
                        r_wd <= '0;
                    end else begin
                        r_wd <= r_wd + c_WD_ONE;
                    end
                    if (r_wr_cnt == c_N_ELEM) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (!core_valid && r_wd == c_WD_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand-valid strobe tracks the read enable through the BRAM latency.
    generate
        if (MEM_LAT == 1) begin : g_lat_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= r_rd_en;
                end
            end
        end else begin : g_lat_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= {r_vpipe[MEM_LAT-2:0], r_rd_en};
                end
            end
        end
    endgenerate

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign a_valid = r_vpipe[MEM_LAT-1];
    assign b_valid = r_vpipe[MEM_LAT-1];
    assign core_op = r_core_op;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_complex_array_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_complex_array_seq_ctrl
// Brief    : Self-checking bench for complex_array_seq_ctrl with BRAM and core models.
// Revision : 1.0
// ============================================================================
module tb_complex_array_seq_ctrl;

    localparam int N = 16;
    localparam int M = 1;
    localparam int C = 2;
    localparam int T = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        operation;
    logic        busy, done, err, rd_en, a_valid, b_valid, core_op, wr_en;
    logic [3:0]  rd_addr, wr_addr;
    logic [31:0] wr_data;
    logic        core_valid;
    logic [15:0] core_re, core_im;

    int n_cmp  = 0;
    int n_fail = 0;

    complex_array_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .operation  (operation),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .core_op    (core_op),
        .core_valid (core_valid),
        .core_re    (core_re),
        .core_im    (core_im),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: operand BRAMs (latency 1) and a registered add/sub core (latency 2).
    logic [15:0] mem_are[N], mem_aim[N], mem_bre[N], mem_bim[N];
    logic [15:0] q_are, q_aim, q_bre, q_bim;
    logic        s1_v, s2_v;
    logic [15:0] s1_re, s1_im, s2_re, s2_im;
    int          cv_cnt;
    int          drop_lim = N;
    logic        cv_clr = 1'b0;
    logic        spur = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_are <= '0; q_aim <= '0; q_bre <= '0; q_bim <= '0;
            s1_v <= 1'b0; s2_v <= 1'b0;
            s1_re <= '0; s1_im <= '0; s2_re <= '0; s2_im <= '0;
            cv_cnt <= 0;
        end else begin
            if (rd_en) begin
                q_are <= mem_are[rd_addr]; q_aim <= mem_aim[rd_addr];
                q_bre <= mem_bre[rd_addr]; q_bim <= mem_bim[rd_addr];
            end
            s1_v  <= a_valid && b_valid;
            s1_re <= core_op ? q_are - q_bre : q_are + q_bre;
            s1_im <= core_op ? q_aim - q_bim : q_aim + q_bim;
            s2_v  <= s1_v;
            s2_re <= s1_re;
            s2_im <= s1_im;
            if (cv_clr) cv_cnt <= 0;
            else if (s2_v && cv_cnt < drop_lim) cv_cnt <= cv_cnt + 1;
        end
    end

    assign core_valid = (s2_v && cv_cnt < drop_lim) || spur;
    assign core_re    = s2_re;
    assign core_im    = s2_im;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input int k, input logic op);
        logic [15:0] re, im;
        re = op ? mem_are[k] - mem_bre[k] : mem_are[k] + mem_bre[k];
        im = op ? mem_aim[k] - mem_bim[k] : mem_aim[k] + mem_bim[k];
        return {re, im};
    endfunction

    // Completion cycle from the timeline rules: full runs finish at N+2+M+C,
    // short runs finish T cycles after the first result-free DRAIN cycle.
    function automatic int model_done(input int nw);
        int last_v, first_idle;
        if (nw >= N) return N + 2 + M + C;
        last_v     = M + C + nw;
        first_idle = (last_v + 1 > N + 1) ? last_v + 1 : N + 1;
        return first_idle + T;
    endfunction

    function automatic logic [7:0] flags();
        return {busy, done, err, rd_en, a_valid, b_valid, core_op, wr_en};
    endfunction

    task automatic load_plan_data();
        for (int i = 0; i < N; i++) begin
            mem_are[i] = 16'(i);
            mem_aim[i] = 16'(2 * i);
            mem_bre[i] = 16'd1;
            mem_bim[i] = 16'd1;
        end
    endtask

    // Called in cycle 0 (just after an edge); checks every output cycle by cycle.
    task automatic run_op(input logic op, input int nw, input bit extra,
                          input int exp_done, input bit exp_err);
        int n_rd = 0, n_wr = 0, n_done = 0;
        logic [7:0] ef;
        drop_lim  = nw;
        start     = 1'b1;
        operation = op;
        cv_clr    = 1'b1;
        for (int c = 1; c <= exp_done + 3; c++) begin
            @(posedge clk); #1;
            cv_clr = 1'b0;
            start  = (extra && (c == 3 || c == exp_done)) ? 1'b1 : 1'b0;
            operation = start ? ~op : op;
            ef = {c <= exp_done,
                  c == exp_done,
                  (c >= exp_done) ? exp_err : 1'b0,
                  c <= N,
                  c >= 1 + M && c <= N + M,
                  c >= 1 + M && c <= N + M,
                  op,
                  c >= 2 + M + C && c < 2 + M + C + nw};
            chk($sformatf("flags c%0d", c), {24'd0, flags()}, {24'd0, ef});
            if (rd_en) n_rd++;
            if (wr_en) n_wr++;
            if (done)  n_done++;
            if (ef[4]) chk($sformatf("rd_addr c%0d", c), {28'd0, rd_addr}, 32'(c - 1));
            if (ef[0]) begin
                chk($sformatf("wr_addr c%0d", c), {28'd0, wr_addr}, 32'(c - 2 - M - C));
                chk($sformatf("wr_data c%0d", c), wr_data, exp_word(c - 2 - M - C, op));
            end
        end
        start = 1'b0;
        chk("rd_en count", 32'(n_rd), 32'(N));
        chk("wr_en count", 32'(n_wr), 32'(nw));
        chk("done count", 32'(n_done), 32'd1);
    endtask

    typedef struct {
        logic op;
        int   nw;
        bit   extra;
        int   exp_done;
        bit   exp_err;
    } vec_t;

    vec_t tbl[6];
    bit   last_err;

    initial begin
        tbl[0] = '{op: 1'b0, nw: 16, extra: 1'b0, exp_done: 21, exp_err: 1'b0};
        tbl[1] = '{op: 1'b1, nw: 16, extra: 1'b0, exp_done: 21, exp_err: 1'b0};
        tbl[2] = '{op: 1'b0, nw: 16, extra: 1'b1, exp_done: 21, exp_err: 1'b0};
        tbl[3] = '{op: 1'b1, nw: 10, extra: 1'b0, exp_done: 25, exp_err: 1'b1};
        tbl[4] = '{op: 1'b0, nw: 14, extra: 1'b0, exp_done: 26, exp_err: 1'b1};
        tbl[5] = '{op: 1'b0, nw: 0,  extra: 1'b0, exp_done: 25, exp_err: 1'b1};

        load_plan_data();
        rst_n = 1'b0; start = 1'b0; operation = 1'b0;
        #3;
        chk("reset flags", {24'd0, flags()}, 32'd0);
        chk("reset addrs", {24'd0, rd_addr, wr_addr}, 32'd0);
        chk("reset wr_data", wr_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Spurious core_valid while idle must never write.
        for (int i = 0; i < 4; i++) begin
            spur = (i < 3);
            @(posedge clk); #1;
            chk($sformatf("idle spur wr_en %0d", i), {31'd0, wr_en}, 32'd0);
            chk($sformatf("idle spur wr_addr %0d", i), {28'd0, wr_addr}, 32'd0);
        end
        spur = 1'b0;

        for (int t = 0; t < 6; t++) begin
            run_op(tbl[t].op, tbl[t].nw, tbl[t].extra, tbl[t].exp_done, tbl[t].exp_err);
            last_err = tbl[t].exp_err;
            for (int g = 0; g < 2; g++) begin
                @(posedge clk); #1;
                chk($sformatf("err hold v%0d", t), {31'd0, err}, {31'd0, last_err});
            end
        end

        // Abort mid-operation with an asynchronous reset.
        start = 1'b1; operation = 1'b1; drop_lim = N; cv_clr = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            start = 1'b0; cv_clr = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("async reset flags", {24'd0, flags()}, 32'd0);
        chk("async reset addrs", {24'd0, rd_addr, wr_addr}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("held reset flags %0d", i), {24'd0, flags()}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post reset flags %0d", i), {24'd0, flags()}, 32'd0);
        end
        run_op(1'b0, N, 1'b0, model_done(N), 1'b0);
        @(posedge clk); #1;

        // Random operand data, operation and result-drop point.
        for (int r = 0; r < 6; r++) begin
            int nw;
            logic op;
            for (int i = 0; i < N; i++) begin
                mem_are[i] = 16'($urandom); mem_aim[i] = 16'($urandom);
                mem_bre[i] = 16'($urandom); mem_bim[i] = 16'($urandom);
            end
            op = 1'($urandom_range(0, 1));
            nw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : N;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            run_op(op, nw, 1'b0, model_done(nw), nw < N);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/complex_array_seq_ctrl.md
Name: complex_array_seq_ctrl

Overview:
Sequencer for the complex array add/sub datapath. On `start` it streams element indices 0..N_ELEM-1 to the A and B operand memories. It drives the operand-valid strobes and the add/sub select into the complex add/sub core, captures the core results into the result memory, and reports `done` or `err`. It sits between the top-level command interface and the operand/result BRAMs plus the add/sub IP core.

Parameters:
- N_ELEM, 16, number of complex elements per operation (≥2)
- ADDR_W, 4, memory address width; 2^ADDR_W ≥ N_ELEM
- DATA_W, 16, width of one real or imag component
- MEM_LAT, 1, operand BRAM read latency in cycles (≥1)
- CORE_LAT, 2, add/sub core latency from a_valid/b_valid to core_valid (≥1)
- TO_CYC, 8, watchdog: maximum idle cycles in DRAIN before error

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe, sampled only in IDLE
- operation  in  1  0 = add (A+B), 1 = subtract (A−B); latched at start
- busy  out  1  high from ISSUE through DONE
- done  out  1  one-cycle completion pulse
- err  out  1  high with done when the watchdog fired; held until next accepted start
- rd_en  out  1  operand memory read enable
- rd_addr  out  ADDR_W  operand read address, shared by A and B memories
- a_valid  out  1  operand A valid to core
- b_valid  out  1  operand B valid to core; always equal to a_valid
- core_op  out  1  add/sub select to core; latched operation
- core_valid  in  1  core result valid
- core_re  in  DATA_W  core result, real part
- core_im  in  DATA_W  core result, imaginary part
- wr_en  out  1  result memory write enable
- wr_addr  out  ADDR_W  result write address
- wr_data  out  2*DATA_W  {re, im} result word

Behaviour:
- Reset, async on rst_n low:
  - FSM = IDLE.
  - All outputs 0; rd_addr = wr_addr = 0.
  - Valid pipeline, counters and watchdog cleared; core_op = 0.
  - Reset mid-operation aborts immediately; no done pulse.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 → latch operation into core_op, clear err, rd counter=0, wr counter=0, go to ISSUE.
  - start ignored in every other state.
- ISSUE:
  - rd_en=1, rd_addr = rd counter, counter increments each cycle.
  - After the cycle with rd_addr = N_ELEM−1 → DRAIN.
  - Exactly N_ELEM rd_en cycles, no gaps.
- a_valid/b_valid = rd_en delayed by MEM_LAT registers (shift register, no gaps).
- Write path, registered:
  - In cycle after core_valid=1 (states ISSUE/DRAIN/DONE-entry only): wr_en=1, wr_data={core_re,core_im}, wr_addr = wr counter; wr counter then increments.
  - core_valid in IDLE is ignored.
  - core_valid after N_ELEM results have been captured is ignored (no write, no wrap).
- DRAIN:
  - Watchdog counts cycles with no core_valid and is cleared on each core_valid.
  - After the last write is issued (wr counter reaches N_ELEM) → DONE.
  - Watchdog reaching TO_CYC → set err, go to DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE. A start in the DONE cycle is ignored.
- Timing (cycle 0 = cycle where start is sampled high):
  - rd_en in cycles 1..N.
  - a_valid in cycles 1+M..N+M.
  - Expected core_valid in cycles 1+M+C..N+M+C.
  - wr_en in cycles 2+M+C..N+1+M+C.
  - done in cycle N+2+M+C. Defaults: cycle 21, busy cycles 1..21.
- Counters are ADDR_W+1 bits internally, so N_ELEM = 2^ADDR_W terminates correctly without address wrap.
- No arithmetic is performed in this block; core results pass through bit-exact.

Test Plan:
- Add run: bench core model = registered A+B, latency 2; A[i]=(i, 2i), B[i]=(1, 1), op=0, start at cycle 0 → 16 writes at cycles 5..20, wr_data[i] = {i+1, 2i+1}, done=1 only in cycle 21, err=0.
- Subtract run: same data, op=1 → wr_data[i] = {i−1, 2i−1} (two's complement; i=0 gives {FFFF, FFFF}); core_op=1 through DONE.
- Start during busy: second start pulses at cycles 3 and 21 → ignored; exactly one done; rd_en count = 16.
- Watchdog: core model drops every core_valid after the 10th → err=1 and done in the cycle the watchdog hits 8 idle DRAIN cycles; wr_en count = 10; err stays 1 until the next start.
- Reset mid-op: rst_n low at cycle 8 → all outputs 0 asynchronously, no done. New start after release → full 16-element run completes normally.
- Spurious core_valid in IDLE → no wr_en; wr_addr stays 0.
